// File: rtl/std_pipereg_pkg.sv
// Shared helpers for the std_pipereg handshaked pipeline register.
// Only the occupancy-count width lives here; each stage keeps its own plain types.
package std_pipereg_pkg;

  function automatic int std_pipereg_cntw(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/std_pipereg_stage.sv
// One pipeline stage: valid bit plus data register; 1-cycle latency, holds while load is low.
// Data loads only under an incoming valid beat; flush drops the valid bit and keeps the data.
module std_pipereg_stage #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             vin,
  input  logic [WIDTH-1:0] din,
  output logic             vout,
  output logic [WIDTH-1:0] dout
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (load) begin
      v_d = vin;
      if (vin) d_d = din;
    end
    if (flush) begin
      v_d = 1'b0;
      d_d = d_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= 1'b0;
      d_q <= RESET_VALUE;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign vout = v_q;
  assign dout = d_q;

endmodule

// File: rtl/std_pipereg.sv
// DEPTH-stage valid/ready pipeline register with bubble collapse, flush and occupancy count; latency DEPTH.
// Optional STD_PIPEREG_SKID_EN adds a one-entry skid so in_ready is registered instead of combinational from out_ready.
module std_pipereg
  import std_pipereg_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [WIDTH-1:0]                     in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [WIDTH-1:0]                     out_data,
  output logic [std_pipereg_cntw(DEPTH)-1:0]   count
);

  localparam int CW = std_pipereg_cntw(DEPTH);

  logic [DEPTH-1:0] v, adv, st_vin;
  logic [WIDTH-1:0] d      [DEPTH];
  logic [WIDTH-1:0] st_din [DEPTH];
  logic             adv_run;
  logic             src_v, accept, pop;
  logic [WIDTH-1:0] src_d;
  logic [CW-1:0]    count_q, count_d;

  // A stage may advance if it or any stage downstream of it is empty.
  always_comb begin
    adv_run = out_ready;
    adv     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv_run = adv_run | ~v[i];
      adv[i]  = adv_run;
    end
  end

`ifdef STD_PIPEREG_SKID_EN
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;

  assign in_ready = ~skid_v_q & ~flush & ~reset;
  assign accept   = in_valid & in_ready;
  assign src_v    = skid_v_q | accept;
  assign src_d    = skid_v_q ? skid_data_q : in_data;

  always_comb begin
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    if (skid_v_q && adv[0]) skid_v_d = 1'b0;
    if (accept && !adv[0]) begin
      skid_v_d    = 1'b1;
      skid_data_d = in_data;
    end
    if (flush) skid_v_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      skid_v_q    <= 1'b0;
      skid_data_q <= RESET_VALUE;
    end else begin
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
    end
  end
`else
  assign in_ready = adv[0] & ~flush & ~reset;
  assign accept   = in_valid & in_ready;
  assign src_v    = accept;
  assign src_d    = in_data;
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign st_vin[i] = src_v;
      assign st_din[i] = src_d;
    end else begin : g_body
      assign st_vin[i] = v[i-1];
      assign st_din[i] = d[i-1];
    end

    std_pipereg_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .load  (adv[i]),
      .vin   (st_vin[i]),
      .din   (st_din[i]),
      .vout  (v[i]),
      .dout  (d[i])
    );
  end

  assign pop = v[DEPTH-1] & out_ready;

  always_comb begin
    count_d = count_q;
    if (accept && !pop)      count_d = count_q + CW'(1);
    else if (!accept && pop) count_d = count_q - CW'(1);
    if (flush) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign count     = count_q;

endmodule
